quad_encoder_decoder: RTL and testbench
=======================================

# quad_encoder_decoder

- Reads back one motor's incremental quadrature encoder: the feedback counterpart to the H-bridge driver channel.
- Synchronises and glitch-filters the A/B channels, then decodes them in 4x mode.
- Maintains a signed, wrapping position count.
- Reports a signed velocity (counts per fixed window) plus direction and error status for the closed-loop speed/position controller.

## Interface
Parameters:
- CNT_W, 16: width of position and velocity outputs (two's complement)
- FILT_LEN, 4: consecutive stable cycles required before a filtered input changes; range 1..255
- VEL_WINDOW, 50000: velocity measurement window in clk cycles; ≥2

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-low
- enc_a  in  1  encoder channel A; asynchronous
- enc_b  in  1  encoder channel B; asynchronous
- clear  in  1  synchronous clear of position, error and velocity accumulation
- position  out  CNT_W  signed position count
- velocity  out  CNT_W  signed counts in the last completed window
- vel_valid  out  1  one-cycle pulse when velocity updates
- direction  out  1  direction of last valid step
  - 1 = forward: A leads B; same polarity as the driver direction input
- err  out  1  sticky illegal-transition flag

## Operation
- Input path per channel:
  - 2-FF synchroniser.
  - Filter holding a filtered level and a stability counter. When the synchronised level differs from the filtered level, the counter increments; otherwise it resets to 0. When the count reaches FILT_LEN, the filtered level takes the new value and the counter resets.
- Decoder compares previous and current filtered {A,B}:
  - Forward sequence: 00→10→11→01→00, gives +1.
  - Reverse sequence: gives −1.
  - No change: 0.
  - Both bits changed: illegal. Sets err, no count, direction unchanged.
- Position: adds step each cycle, modulo 2^CNT_W. 0x7FFF+1 wraps to 0x8000 and 0x0000−1 wraps to 0xFFFF (CNT_W=16).
- direction updates only on a valid ±1 step.
- Velocity:
  - Window counter runs 0..VEL_WINDOW−1. The accumulator sums steps and saturates at the signed CNT_W limits; it does not wrap.
  - At terminal count, velocity takes accumulator plus the step of that cycle, vel_valid pulses, and the accumulator and window counter restart from 0.
- clear:
  - Zeroes position, accumulator and window counter, and clears err.
  - velocity and direction hold their values.
  - clear wins over a same-cycle step and over a window terminal count; no vel_valid that cycle.
- Reset (rst=0), effective at the next clk edge:
  - Outputs: position=0, velocity=0, vel_valid=0, direction=1, err=0.
  - Internal state: synchronisers, filtered levels, stability counters, previous-state register, accumulator and window counter all 0.
  - Reset mid-window discards the partial accumulation.
- First sample after reset: previous state is 00. If the encoder rests at 11, the first filtered update appears as an illegal transition and sets err. Software issues clear after reset; this behaviour is required and tested.

## Timing
- Input change sampled at edge k → filtered level changes at edge k+1+FILT_LEN → position/direction/err registered at edge k+2+FILT_LEN. FILT_LEN=4 gives 6-cycle latency.
- Glitch shorter than FILT_LEN cycles (post-sync) produces no step.
- Maximum decodable edge rate: one filtered transition per FILT_LEN+1 cycles per channel.
- vel_valid occurs every VEL_WINDOW cycles after reset/clear deassertion: first at the VEL_WINDOW-th edge.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package quad_pkg:
  - Step encoding constants STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR.
  - Pure function decode_step(prev_ab, cur_ab) returning step code.
  - Shared with a future dual-channel wrapper.
- Sub-module quad_input_filter: synchroniser + stability filter, parameter FILT_LEN, one instance per channel.
- Top level holds decoder, position, direction/err and velocity window logic.

## Test plan
- Reset, clear, then 8 forward quadrature steps spaced 10 cycles apart → position=8, direction=1, err=0, each update 6 cycles after the input edge (FILT_LEN=4).
- Glitch of 3 cycles on enc_a with B static → position unchanged. A 4-cycle pulse → +1 then −1 step.
- Position preloaded to 0x7FFF by 32767 forward steps, then one more forward step → 0x8000. From 0 after clear, one reverse step → 0xFFFF.
- Inject 00→11 directly (both channels change together) → err=1, position unchanged; clear → err=0.
- VEL_WINDOW=100, steps every 10 cycles forward → velocity≈+10 with a one-cycle vel_valid every 100 cycles. Reverse direction → −10. Assert clear on the terminal cycle → no vel_valid, window restarts.
- Assert rst=0 mid-window with 5 counts accumulated → all outputs return to reset values next edge. Next vel_valid occurs VEL_WINDOW cycles after rst=1 and excludes the pre-reset counts.

Source files
------------

// File: rtl/quad_encoder_decoder_pkg.sv
// Shared quadrature step encoding and 4x decode table.
// Used by the single-channel decoder and a future dual-channel wrapper.
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Forward is A leading B: {A,B} = 00 -> 10 -> 11 -> 01 -> 00.
    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_e s;
        s = STEP_NONE;
        case ({prev_ab, cur_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_FWD;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: s = STEP_ERR;
            default:                                s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the input after FILT_LEN consecutive differing samples.
module quad_input_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q, filt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cnt_inc = cnt_q + 8'd1;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_inc == 8'(FILT_LEN)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder feedback: filtered A/B, 4x decode, wrapping position,
// windowed saturating velocity, direction and sticky illegal-transition flag.
module quad_encoder_decoder
    import quad_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned VEL_WINDOW = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [CNT_W-1:0] position,
    output logic [CNT_W-1:0] velocity,
    output logic             vel_valid,
    output logic             direction,
    output logic             err
);

    localparam int unsigned          WIN_W    = $clog2(VEL_WINDOW);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(VEL_WINDOW - 1);
    localparam logic [CNT_W-1:0]     SAT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]     SAT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

    logic             filt_a, filt_b;
    logic [1:0]       cur_ab;
    step_e            step;
    logic [CNT_W:0]   step_ext;
    logic [CNT_W:0]   acc_sum;
    logic [CNT_W-1:0] acc_sat;

    logic [1:0]       prev_ab_q, prev_ab_d;
    logic [CNT_W-1:0] position_q, position_d;
    logic [CNT_W-1:0] velocity_q, velocity_d;
    logic             vel_valid_q, vel_valid_d;
    logic             direction_q, direction_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [WIN_W-1:0] win_q, win_d;

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .din  (enc_a),
        .dout (filt_a)
    );

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .din  (enc_b),
        .dout (filt_b)
    );

    assign cur_ab = {filt_a, filt_b};

    always_comb begin
        step = decode_step(prev_ab_q, cur_ab);
        case (step)
            STEP_FWD: step_ext = (CNT_W+1)'(1);
            STEP_REV: step_ext = '1;
            default:  step_ext = '0;
        endcase

        // One guard bit: overflow shows as disagreement between the top two bits.
        acc_sum = {acc_q[CNT_W-1], acc_q} + step_ext;
        if (acc_sum[CNT_W] != acc_sum[CNT_W-1]) begin
            acc_sat = acc_sum[CNT_W] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_sat = acc_sum[CNT_W-1:0];
        end

        prev_ab_d   = cur_ab;
        position_d  = position_q;
        velocity_d  = velocity_q;
        vel_valid_d = 1'b0;
        direction_d = direction_q;
        err_d       = err_q;
        acc_d       = acc_q;
        win_d       = win_q;

        if (clear) begin
            position_d = '0;
            acc_d      = '0;
            win_d      = '0;
            err_d      = 1'b0;
        end else begin
            position_d = position_q + step_ext[CNT_W-1:0];
            if (step == STEP_FWD) begin
                direction_d = 1'b1;
            end else if (step == STEP_REV) begin
                direction_d = 1'b0;
            end
            if (step == STEP_ERR) begin
                err_d = 1'b1;
            end
            if (win_q == WIN_LAST) begin
                velocity_d  = acc_sat;
                vel_valid_d = 1'b1;
                acc_d       = '0;
                win_d       = '0;
            end else begin
                acc_d = acc_sat;
                win_d = win_q + WIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_ab_q   <= '0;
            position_q  <= '0;
            velocity_q  <= '0;
            vel_valid_q <= 1'b0;
            direction_q <= 1'b1;
            err_q       <= 1'b0;
            acc_q       <= '0;
            win_q       <= '0;
        end else begin
            prev_ab_q   <= prev_ab_d;
            position_q  <= position_d;
            velocity_q  <= velocity_d;
            vel_valid_q <= vel_valid_d;
            direction_q <= direction_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
        end
    end

    assign position  = position_q;
    assign velocity  = velocity_q;
    assign vel_valid = vel_valid_q;
    assign direction = direction_q;
    assign err       = err_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Bench for quad_encoder_decoder: per-cycle behavioural model plus directed
// literal checks; a second instance with FILT_LEN=1 covers the position wrap.
module tb_quad_encoder_decoder;

    localparam int FL = 4;
    localparam int VW = 100;

    logic        clk = 1'b0;
    logic        rst, enc_a, enc_b, clear;
    logic [15:0] position, velocity;
    logic        vel_valid, direction, err;

    logic        wa, wb, wclear;
    logic [15:0] w_position, w_velocity;
    logic        w_vel_valid, w_direction, w_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int cur_idx = 0;
    int w_idx = 0;
    int vv_count = 0;
    logic [15:0] last_vel = '0;

    quad_encoder_decoder #(.CNT_W(16), .FILT_LEN(FL), .VEL_WINDOW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .clear     (clear),
        .position  (position),
        .velocity  (velocity),
        .vel_valid (vel_valid),
        .direction (direction),
        .err       (err)
    );

    quad_encoder_decoder #(.CNT_W(16), .FILT_LEN(1), .VEL_WINDOW(VW)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .enc_a     (wa),
        .enc_b     (wb),
        .clear     (wclear),
        .position  (w_position),
        .velocity  (w_velocity),
        .vel_valid (w_vel_valid),
        .direction (w_direction),
        .err       (w_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Quadrature phase index -> {A,B}; index +1 is one forward count.
    function automatic logic [1:0] gray(input int i);
        case (i)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    bit m_s1a, m_s2a, m_fa, m_s1b, m_s2b, m_fb;
    bit ha[$];
    bit hb[$];
    logic [1:0] m_prev;
    int m_pos, m_acc, m_win, m_vel;
    bit m_vv, m_dir, m_err;

    always @(posedge clk) begin
        int d, step;
        bit all_diff;
        logic [1:0] cur;
        if (!rst) begin
            m_s1a = 0; m_s2a = 0; m_fa = 0;
            m_s1b = 0; m_s2b = 0; m_fb = 0;
            ha.delete(); hb.delete();
            m_prev = 2'b00;
            m_pos = 0; m_acc = 0; m_win = 0; m_vel = 0;
            m_vv = 0; m_dir = 1; m_err = 0;
        end else begin
            cur = {m_fa, m_fb};
            d = (gidx(cur) - gidx(m_prev) + 4) % 4;
            step = (d == 1) ? 1 : (d == 3) ? -1 : 0;

            // filtered level flips once the last FL synchronised samples all disagree with it
            ha.push_back(m_s2a);
            if (ha.size() > FL) ha.delete(0);
            all_diff = (ha.size() == FL);
            foreach (ha[i]) if (ha[i] == m_fa) all_diff = 0;
            if (all_diff) m_fa = ~m_fa;
            hb.push_back(m_s2b);
            if (hb.size() > FL) hb.delete(0);
            all_diff = (hb.size() == FL);
            foreach (hb[i]) if (hb[i] == m_fb) all_diff = 0;
            if (all_diff) m_fb = ~m_fb;
            m_s2a = m_s1a; m_s1a = enc_a;
            m_s2b = m_s1b; m_s1b = enc_b;
            m_prev = cur;

            m_vv = 0;
            if (clear) begin
                m_pos = 0; m_acc = 0; m_win = 0; m_err = 0;
            end else begin
                m_pos = (m_pos + step + 65536) % 65536;
                if (step != 0) m_dir = (step > 0);
                if (d == 2) m_err = 1;
                if (m_win == VW - 1) begin
                    m_vel = sat16(m_acc + step);
                    m_vv = 1; m_acc = 0; m_win = 0;
                end else begin
                    m_acc = sat16(m_acc + step);
                    m_win = m_win + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("position", {16'h0, position}, 32'(m_pos));
            check("velocity", {16'h0, velocity}, {16'h0, 16'(m_vel)});
            check("vel_valid", {31'h0, vel_valid}, {31'h0, m_vv});
            check("direction", {31'h0, direction}, {31'h0, m_dir});
            check("err", {31'h0, err}, {31'h0, m_err});
            if (vel_valid) begin
                last_vel = velocity;
                vv_count++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // lat = edges after the sampling edge until position changes (-1 if never)
    task automatic do_step(input bit fwd, input int spacing, output int lat);
        logic [15:0] old;
        old = position;
        cur_idx = fwd ? (cur_idx + 1) % 4 : (cur_idx + 3) % 4;
        {enc_a, enc_b} = gray(cur_idx);
        lat = -1;
        for (int i = 1; i <= spacing; i++) begin
            tick(1);
            if (lat < 0 && position != old) lat = i - 1;
        end
    endtask

    task automatic w_step(input bit fwd);
        w_idx = fwd ? (w_idx + 1) % 4 : (w_idx + 3) % 4;
        {wa, wb} = gray(w_idx);
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n;
        bit saw9;
        rst = 1'b0; clear = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
        wa = 1'b0; wb = 1'b0; wclear = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick(2);
        check("rst_position", {16'h0, position}, 32'h0);
        check("rst_direction", {31'h0, direction}, 32'h1);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_vel_valid", {31'h0, vel_valid}, 32'h0);
        rst = 1'b1;
        pulse_clear();

        for (int i = 0; i < 8; i++) begin
            do_step(1'b1, 10, lat);
            check("fwd_latency", 32'(lat), 32'd6);
        end
        check("fwd8_position", {16'h0, position}, 32'd8);
        check("fwd8_direction", {31'h0, direction}, 32'h1);
        check("fwd8_err", {31'h0, err}, 32'h0);

        enc_a = 1'b1; tick(3); enc_a = 1'b0; tick(15);
        check("glitch3_position", {16'h0, position}, 32'd8);

        saw9 = 1'b0;
        enc_a = 1'b1; tick(4); enc_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (position == 16'd9) saw9 = 1'b1;
        end
        check("pulse4_saw_plus1", {31'h0, saw9}, 32'h1);
        check("pulse4_position", {16'h0, position}, 32'd8);
        check("pulse4_direction", {31'h0, direction}, 32'h0);

        enc_a = 1'b1; enc_b = 1'b1; tick(12);
        check("illegal_err", {31'h0, err}, 32'h1);
        check("illegal_position", {16'h0, position}, 32'd8);
        check("illegal_direction", {31'h0, direction}, 32'h0);
        enc_a = 1'b0; enc_b = 1'b0; tick(12);
        pulse_clear();
        check("clear_err", {31'h0, err}, 32'h0);
        check("clear_position", {16'h0, position}, 32'h0);

        do_step(1'b0, 10, lat);
        check("rev_latency", 32'(lat), 32'd6);
        check("rev_wrap_position", {16'h0, position}, 32'h0000FFFF);
        check("rev_direction", {31'h0, direction}, 32'h0);
        do_step(1'b1, 10, lat);
        check("unwrap_position", {16'h0, position}, 32'h0);

        pulse_clear();
        vv_count = 0;
        repeat (35) do_step(1'b1, 10, lat);
        check("fwd_velocity", {16'h0, last_vel}, 32'd10);
        check("fwd_vv_count", 32'(vv_count), 32'd3);
        vv_count = 0;
        repeat (35) do_step(1'b0, 10, lat);
        check("rev_velocity", {16'h0, last_vel}, 32'h0000FFF6);
        check("rev_vv_count", 32'(vv_count), 32'd3);

        n = 0;
        while (m_win != VW - 1 && n < 300) begin tick(1); n++; end
        check("term_found", {31'h0, (m_win == VW - 1)}, 32'h1);
        clear = 1'b1; tick(1); clear = 1'b0;
        check("term_clear_no_vv", {31'h0, vel_valid}, 32'h0);
        n = 0;
        while (!vel_valid && n < 150) begin tick(1); n++; end
        check("term_restart_gap", 32'(n), 32'd100);

        // encoder phase here is 0, so 5 steps leave it at {A,B}=10
        pulse_clear();
        repeat (5) do_step(1'b1, 10, lat);
        tick(10);
        rst = 1'b0; tick(1);
        check("midrst_position", {16'h0, position}, 32'h0);
        check("midrst_velocity", {16'h0, velocity}, 32'h0);
        check("midrst_vel_valid", {31'h0, vel_valid}, 32'h0);
        check("midrst_direction", {31'h0, direction}, 32'h1);
        check("midrst_err", {31'h0, err}, 32'h0);
        rst = 1'b1;
        n = 0;
        while (!vel_valid && n < 150) begin tick(1); n++; end
        check("midrst_restart_gap", 32'(n), 32'd100);
        // only the re-acquired 00->10 step after reset counts
        check("midrst_velocity_window", {16'h0, velocity}, 32'd1);

        do_step(1'b1, 10, lat);
        rst = 1'b0; tick(1); rst = 1'b1;
        tick(12);
        check("rest11_err", {31'h0, err}, 32'h1);
        check("rest11_position", {16'h0, position}, 32'h0);
        pulse_clear();
        check("rest11_clear_err", {31'h0, err}, 32'h0);

        wclear = 1'b1; tick(1); wclear = 1'b0;
        for (int i = 0; i < 32767; i++) w_step(1'b1);
        tick(6);
        check("wrap_preload", {16'h0, w_position}, 32'h00007FFF);
        check("wrap_preload_err", {31'h0, w_err}, 32'h0);
        w_step(1'b1);
        tick(6);
        check("wrap_pos_to_neg", {16'h0, w_position}, 32'h00008000);
        check("wrap_direction", {31'h0, w_direction}, 32'h1);
        wclear = 1'b1; tick(1); wclear = 1'b0;
        w_step(1'b0);
        tick(6);
        check("wrap_zero_minus_one", {16'h0, w_position}, 32'h0000FFFF);
        check("wrap_rev_direction", {31'h0, w_direction}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
